// File: rtl/universal_shift_reg.sv
// Universal shift register: N bits, L-bit lanes, shift/rotate/load/clear with frame counter.
// Optional parity output enabled by defining USR_PARITY_EN.
module universal_shift_reg #(
   parameter int N  = 8,
   parameter int L  = 1,
   parameter int CW = ((N / L) > 1) ? $clog2(N / L) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [2:0]    mode,
   input  logic [L-1:0]  sin,
   input  logic [N-1:0]  pin,
   output logic [L-1:0]  sout,
   output logic [N-1:0]  pout,
   output logic [CW-1:0] cnt,
   output logic          frame_done,
   output logic          par_out
);

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHL   = 3'b001;
   localparam logic [2:0] MODE_SHR   = 3'b010;
   localparam logic [2:0] MODE_ROL   = 3'b011;
   localparam logic [2:0] MODE_ROR   = 3'b100;
   localparam logic [2:0] MODE_LOAD  = 3'b101;
   localparam logic [2:0] MODE_CLEAR = 3'b110;

   localparam int          LANE_MOD = (L >= 1) ? (N % L) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'((N / L) - 1);

   generate
      if (N < 2 || L < 1 || L > N || LANE_MOD != 0) begin : g_bad_params
         $error("universal_shift_reg: require N >= 2, 1 <= L <= N and N %% L == 0");
      end
   endgenerate

   logic [N-1:0]  pout_r;
   logic [L-1:0]  sout_r;
   logic [CW-1:0] cnt_r;
   logic          frame_done_r;

   logic [N-1:0]  next_pout_s;
   logic [L-1:0]  next_sout_s;
   logic [CW-1:0] next_cnt_s;
   logic          next_frame_done_s;
   logic          shift_op_s;

   // Next-state selection for data, serial output and frame counter.
   always_comb begin
      next_pout_s       = pout_r;
      next_sout_s       = sout_r;
      next_cnt_s        = cnt_r;
      next_frame_done_s = 1'b0;
      shift_op_s        = 1'b0;
      if (en) begin
         case (mode)
            MODE_SHL: begin
               next_pout_s = (pout_r << L) | N'(sin);
               next_sout_s = L'(pout_r >> (N - L));
               shift_op_s  = 1'b1;
            end
            MODE_SHR: begin
               next_pout_s = (pout_r >> L) | (N'(sin) << (N - L));
               next_sout_s = L'(pout_r);
               shift_op_s  = 1'b1;
            end
            MODE_ROL: begin
               next_pout_s = (pout_r << L) | (pout_r >> (N - L));
               next_sout_s = L'(pout_r >> (N - L));
               shift_op_s  = 1'b1;
            end
            MODE_ROR: begin
               next_pout_s = (pout_r >> L) | (pout_r << (N - L));
               next_sout_s = L'(pout_r);
               shift_op_s  = 1'b1;
            end
            MODE_LOAD: begin
               next_pout_s = pin;
               next_sout_s = {L{1'b0}};
               next_cnt_s  = {CW{1'b0}};
            end
            MODE_CLEAR: begin
               next_pout_s = {N{1'b0}};
               next_sout_s = {L{1'b0}};
               next_cnt_s  = {CW{1'b0}};
            end
            MODE_HOLD: begin
               next_pout_s = pout_r;
            end
            default: begin
               next_pout_s = pout_r;
            end
         endcase
      end else begin
         next_pout_s = pout_r;
      end

      // Any shift or rotate advances the frame; the last lane wraps and pulses.
      if (shift_op_s) begin
         if (cnt_r == LAST_CNT) begin
            next_cnt_s        = {CW{1'b0}};
            next_frame_done_s = 1'b1;
         end else begin
            next_cnt_s        = cnt_r + CW'(1);
            next_frame_done_s = 1'b0;
         end
      end else begin
         next_frame_done_s = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pout_r       <= {N{1'b0}};
         sout_r       <= {L{1'b0}};
         cnt_r        <= {CW{1'b0}};
         frame_done_r <= 1'b0;
      end else begin
         pout_r       <= next_pout_s;
         sout_r       <= next_sout_s;
         cnt_r        <= next_cnt_s;
         frame_done_r <= next_frame_done_s;
      end
   end

`ifdef USR_PARITY_EN
   function automatic logic parity_f(input logic [N-1:0] data);
      return ^data;
   endfunction

   logic par_r;

   // Parity tracks the value pout takes on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_r <= 1'b0;
      end else begin
         par_r <= parity_f(next_pout_s);
      end
   end

   assign par_out = par_r;
`else
   assign par_out = 1'b0;
`endif

   assign pout       = pout_r;
   assign sout       = sout_r;
   assign cnt        = cnt_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: an L=1 and an L=2 instance (N=8) share stimulus.
module tb_universal_shift_reg;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [2:0] mode;
   logic [1:0] sin;
   logic [7:0] pin;

   logic       sout_a;
   logic [7:0] pout_a;
   logic [2:0] cnt_a;
   logic       fd_a;
   logic       par_a;

   logic [1:0] sout_b;
   logic [7:0] pout_b;
   logic [1:0] cnt_b;
   logic       fd_b;
   logic       par_b;

   int tests_run = 0;
   int tests_failed = 0;

   universal_shift_reg #(.N(8), .L(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin(sin[0]), .pin(pin),
      .sout(sout_a), .pout(pout_a), .cnt(cnt_a), .frame_done(fd_a), .par_out(par_a)
   );

   universal_shift_reg #(.N(8), .L(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin(sin), .pin(pin),
      .sout(sout_b), .pout(pout_b), .cnt(cnt_b), .frame_done(fd_b), .par_out(par_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [7:0] p;
      logic [1:0] s;
      logic [2:0] c;
      logic       fd;
      logic       par;
   } exp_t;

   exp_t q[$];

   logic [7:0] m_p  [2];
   logic [1:0] m_s  [2];
   logic [2:0] m_c  [2];
   logic       m_fd [2];

   function automatic logic exp_par(input logic [7:0] v);
`ifdef USR_PARITY_EN
      return ^v;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_p[i] = 8'h00; m_s[i] = 2'b00; m_c[i] = 3'd0; m_fd[i] = 1'b0;
      end
   endtask

   task automatic push_exp();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         e.id = i; e.p = m_p[i]; e.s = m_s[i]; e.c = m_c[i]; e.fd = m_fd[i];
         e.par = exp_par(m_p[i]);
         q.push_back(e);
      end
   endtask

   task automatic cmp(input string tag, input int id, input logic [7:0] obs, input logic [7:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, id, obs, exp);
      end
   endtask

   task automatic check_q();
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         if (e.id == 0) begin
            cmp("pout", 0, pout_a, e.p);
            cmp("sout", 0, {7'd0, sout_a}, {6'd0, e.s});
            cmp("cnt", 0, {5'd0, cnt_a}, {5'd0, e.c});
            cmp("frame_done", 0, {7'd0, fd_a}, {7'd0, e.fd});
            cmp("par_out", 0, {7'd0, par_a}, {7'd0, e.par});
         end else begin
            cmp("pout", 1, pout_b, e.p);
            cmp("sout", 1, {6'd0, sout_b}, {6'd0, e.s});
            cmp("cnt", 1, {6'd0, cnt_b}, {5'd0, e.c});
            cmp("frame_done", 1, {7'd0, fd_b}, {7'd0, e.fd});
            cmp("par_out", 1, {7'd0, par_b}, {7'd0, e.par});
         end
      end
   endtask

   // Drive one cycle, advance the reference model, then compare after the edge.
   task automatic step(input logic [2:0] m, input logic [1:0] s, input logic [7:0] pi, input logic e_in);
      logic [7:0] p, np, mask, sv;
      logic [1:0] ns;
      int l, frames;
      logic sh;
      en = e_in; mode = m; sin = s; pin = pi;
      for (int i = 0; i < 2; i++) begin
         l = i + 1;
         frames = 8 / l;
         mask = (l == 1) ? 8'h01 : 8'h03;
         sv = {6'd0, s} & mask;
         p = m_p[i];
         np = p;
         ns = m_s[i];
         sh = 1'b0;
         m_fd[i] = 1'b0;
         if (e_in) begin
            case (m)
               3'b001: begin np = (p << l) | sv; ns = 2'((p >> (8 - l)) & mask); sh = 1'b1; end
               3'b010: begin np = (p >> l) | (sv << (8 - l)); ns = 2'(p & mask); sh = 1'b1; end
               3'b011: begin np = (p << l) | (p >> (8 - l)); ns = 2'((p >> (8 - l)) & mask); sh = 1'b1; end
               3'b100: begin np = (p >> l) | (p << (8 - l)); ns = 2'(p & mask); sh = 1'b1; end
               3'b101: begin np = pi; ns = 2'b00; m_c[i] = 3'd0; end
               3'b110: begin np = 8'h00; ns = 2'b00; m_c[i] = 3'd0; end
               default: begin np = p; end
            endcase
         end
         if (sh) begin
            if (int'(m_c[i]) == frames - 1) begin
               m_c[i] = 3'd0; m_fd[i] = 1'b1;
            end else begin
               m_c[i] = m_c[i] + 3'd1;
            end
         end
         m_p[i] = np;
         m_s[i] = ns;
      end
      push_exp();
      @(posedge clk);
      #1;
      check_q();
   endtask

   initial begin
      logic [7:0] sipo_bits;
      rst_n = 1'b0; en = 1'b0; mode = 3'b000; sin = 2'b00; pin = 8'h00;
      model_reset();
      #12;
      push_exp();
      check_q();
      rst_n = 1'b1;

      // Async reset mid-operation
      step(3'b101, 2'b00, 8'hA5, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      push_exp();
      check_q();
      @(posedge clk);
      #1;
      push_exp();
      check_q();
      rst_n = 1'b1;
      step(3'b000, 2'b11, 8'hFF, 1'b1);
      cmp("hold_after_reset", 0, pout_a, 8'h00);

      // PISO: load then shift out MSB first
      step(3'b101, 2'b00, 8'hB4, 1'b1);
      for (int i = 0; i < 8; i++) step(3'b001, 2'b00, 8'h00, 1'b1);
      cmp("piso_empty", 0, pout_a, 8'h00);

      // SIPO right
      step(3'b110, 2'b00, 8'h00, 1'b1);
      sipo_bits = 8'b01010011;
      for (int i = 0; i < 8; i++) step(3'b010, {1'b0, sipo_bits[i]}, 8'h00, 1'b1);
      cmp("sipo_word", 0, pout_a, 8'h53);

      // Multi-lane rotate on the L=2 instance
      step(3'b101, 2'b00, 8'h1E, 1'b1);
      for (int i = 0; i < 4; i++) step(3'b011, 2'b11, 8'h00, 1'b1);
      cmp("rol_restore", 1, pout_b, 8'h1E);
      cmp("rol_frame", 1, {7'd0, fd_b}, 8'h01);

      // Enable gating and direction change mid-frame
      step(3'b101, 2'b00, 8'hFF, 1'b1);
      for (int i = 0; i < 3; i++) step(3'b001, 2'b00, 8'h00, 1'b1);
      for (int i = 0; i < 5; i++) step(3'b001, 2'b01, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) step(3'b010, 2'b01, 8'h00, 1'b1);
      cmp("mixed_frame", 0, {7'd0, fd_a}, 8'h01);
      step(3'b111, 2'b01, 8'h00, 1'b1);
      step(3'b001, 2'b01, 8'h00, 1'b1);
      step(3'b001, 2'b00, 8'h00, 1'b1);
      step(3'b101, 2'b00, 8'h3C, 1'b1);
      cmp("load_clears_cnt", 0, {5'd0, cnt_a}, 8'h00);

      // Parity
      step(3'b101, 2'b00, 8'h07, 1'b1);
      cmp("par_load", 0, {7'd0, par_a}, {7'd0, exp_par(8'h07)});
      step(3'b001, 2'b01, 8'h00, 1'b1);
      cmp("par_shl_pout", 0, pout_a, 8'h0F);
      cmp("par_shl", 0, {7'd0, par_a}, {7'd0, exp_par(8'h0F)});

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
